// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - iterative 32-bit signed multiply/divide sequencer driving a shared add/sub ALU
//
// Purpose: runs a signed MULT (unsigned shift-add on magnitudes) or signed DIV
// (restoring division on magnitudes), issuing one ALU add/sub per cycle.
// Ports:
//   clock, reset_n           rising-edge clock, asynchronous active-low reset
//   ctrl_MULT, ctrl_DIV      one-cycle start pulses (MULT wins when both high)
//   data_operandA/B          operands, latched at start
//   data_result              registered result
//   data_exception           registered overflow / divide-by-zero flag
//   data_resultRDY           one-cycle done strobe
//   alu_opA/opB/opcode/shamt request to the shared ALU (add=0, sub=1, shamt=0)
//   alu_result               combinational ALU result for the current request
module muldiv_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic [WIDTH-1:0] alu_opA,
  output logic [WIDTH-1:0] alu_opB,
  output logic [4:0]       alu_opcode,
  output logic [4:0]       alu_shamt,
  input  logic [WIDTH-1:0] alu_result
);

  localparam logic [4:0]       OP_ADD  = 5'd0;
  localparam logic [4:0]       OP_SUB  = 5'd1;
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONES    = {WIDTH{1'b1}};

  typedef enum logic [2:0] {IDLE, ABS_A, ABS_B, ITER, SIGN, DONE} state_t;

  state_t           state_q, state_d;
  logic             op_div_q, op_div_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] m_q, m_d;     // |B|
  logic [WIDTH-1:0] hi_q, hi_d;   // product high word / partial remainder
  logic [WIDTH-1:0] lo_q, lo_d;   // product low word / quotient
  logic             sign_q, sign_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             exc_q, exc_d;
  logic [WIDTH-1:0] data_result_q, data_result_d;
  logic             data_exc_q, data_exc_d;
  logic             rdy_q, rdy_d;

  logic             start;
  logic             carry;
  logic             borrow;
  logic [WIDTH:0]   rp;           // shifted remainder before the trial subtract

  assign start          = ctrl_MULT | ctrl_DIV;
  assign alu_shamt      = 5'd0;
  assign data_result    = data_result_q;
  assign data_exception = data_exc_q;
  assign data_resultRDY = rdy_q;

  always_comb begin
    state_d       = state_q;
    op_div_d      = op_div_q;
    a_d           = a_q;
    b_d           = b_q;
    m_d           = m_q;
    hi_d          = hi_q;
    lo_d          = lo_q;
    sign_d        = sign_q;
    cnt_d         = cnt_q;
    res_d         = res_q;
    exc_d         = exc_q;
    data_result_d = data_result_q;
    data_exc_d    = data_exc_q;
    rdy_d         = 1'b0;
    alu_opA       = '0;
    alu_opB       = '0;
    alu_opcode    = OP_ADD;
    carry         = 1'b0;
    borrow        = 1'b0;
    rp            = '0;

    case (state_q)
      ABS_A: begin
        alu_opB    = a_q;
        alu_opcode = OP_SUB;
        lo_d       = a_q[WIDTH-1] ? alu_result : a_q;
        hi_d       = '0;
        sign_d     = a_q[WIDTH-1] ^ b_q[WIDTH-1];
        state_d    = ABS_B;
      end
      ABS_B: begin
        alu_opB    = b_q;
        alu_opcode = OP_SUB;
        m_d        = b_q[WIDTH-1] ? alu_result : b_q;
        cnt_d      = CNT_W'(WIDTH);
        state_d    = ITER;
      end
      ITER: begin
        if (!op_div_q) begin
          alu_opA = hi_q;
          alu_opB = lo_q[0] ? m_q : '0;
          // Carry-out recovered from the operand and sum sign bits.
          carry = lo_q[0] & ((alu_opA[WIDTH-1] & alu_opB[WIDTH-1]) |
                             ((alu_opA[WIDTH-1] | alu_opB[WIDTH-1]) & ~alu_result[WIDTH-1]));
          hi_d  = {carry, alu_result[WIDTH-1:1]};
          lo_d  = {alu_result[0], lo_q[WIDTH-1:1]};
        end else begin
          rp         = {hi_q, lo_q[WIDTH-1]};
          alu_opA    = rp[WIDTH-1:0];
          alu_opB    = m_q;
          alu_opcode = OP_SUB;
          // Set when the 32-bit subtract would need to borrow (opA < opB unsigned).
          borrow = (~alu_opA[WIDTH-1] & alu_opB[WIDTH-1]) |
                   (~(alu_opA[WIDTH-1] ^ alu_opB[WIDTH-1]) & alu_result[WIDTH-1]);
          if (rp[WIDTH] | ~borrow) begin
            hi_d = alu_result;
            lo_d = {lo_q[WIDTH-2:0], 1'b1};
          end else begin
            hi_d = rp[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], 1'b0};
          end
        end
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = SIGN;
      end
      SIGN: begin
        alu_opB    = lo_q;
        alu_opcode = OP_SUB;
        res_d      = sign_q ? alu_result : lo_q;
        if (op_div_q)
          exc_d = (a_q == MIN_VAL) && (b_q == ONES);
        else
          exc_d = (hi_q != '0) || (!sign_q && lo_q[WIDTH-1]) || (sign_q && (lo_q > MIN_VAL));
        state_d = DONE;
      end
      DONE: begin
        data_result_d = res_q;
        data_exc_d    = exc_q;
        rdy_d         = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A start in any state discards whatever was in flight.
    if (start) begin
      op_div_d      = ~ctrl_MULT;
      a_d           = data_operandA;
      b_d           = data_operandB;
      m_d           = '0;
      hi_d          = '0;
      lo_d          = '0;
      sign_d        = 1'b0;
      cnt_d         = '0;
      data_result_d = data_result_q;
      data_exc_d    = 1'b0;
      rdy_d         = 1'b0;
      if (!ctrl_MULT && (data_operandB == '0)) begin
        res_d   = '0;
        exc_d   = 1'b1;
        state_d = DONE;
      end else begin
        state_d = ABS_A;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      op_div_q      <= 1'b0;
      a_q           <= '0;
      b_q           <= '0;
      m_q           <= '0;
      hi_q          <= '0;
      lo_q          <= '0;
      sign_q        <= 1'b0;
      cnt_q         <= '0;
      res_q         <= '0;
      exc_q         <= 1'b0;
      data_result_q <= '0;
      data_exc_q    <= 1'b0;
      rdy_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_div_q      <= op_div_d;
      a_q           <= a_d;
      b_q           <= b_d;
      m_q           <= m_d;
      hi_q          <= hi_d;
      lo_q          <= lo_d;
      sign_q        <= sign_d;
      cnt_q         <= cnt_d;
      res_q         <= res_d;
      exc_q         <= exc_d;
      data_result_q <= data_result_d;
      data_exc_q    <= data_exc_d;
      rdy_q         <= rdy_d;
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - self-checking bench for muldiv_seq with an arithmetic reference model
module tb_muldiv_seq;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        ctrl_MULT = 1'b0;
  logic        ctrl_DIV = 1'b0;
  logic [31:0] data_operandA = '0;
  logic [31:0] data_operandB = '0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic [31:0] alu_opA, alu_opB, alu_result;
  logic [4:0]  alu_opcode, alu_shamt;

  muldiv_seq #(.WIDTH(32), .CNT_W(6)) dut (
    .clock(clock), .reset_n(reset_n), .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .data_operandA(data_operandA), .data_operandB(data_operandB),
    .data_result(data_result), .data_exception(data_exception), .data_resultRDY(data_resultRDY),
    .alu_opA(alu_opA), .alu_opB(alu_opB), .alu_opcode(alu_opcode), .alu_shamt(alu_shamt),
    .alu_result(alu_result)
  );

  assign alu_result = (alu_opcode == 5'd1) ? alu_opA - alu_opB : alu_opA + alu_opB;

  always #5 clock = ~clock;

  int          cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int          checks = 0;
  int          errors = 0;
  int          exp_at = -1;
  logic [31:0] exp_res = '0;
  logic        exp_exc = 1'b0;
  logic [31:0] held_res = '0;
  logic        held_exc = 1'b0;

  localparam longint MAX_P = 64'sd2147483647;
  localparam longint MIN_N = -64'sd2147483648;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic void model(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic e);
    longint la, lb, p;
    la = longint'($signed(a));
    lb = longint'($signed(b));
    if (!is_div) begin
      p = la * lb;
      r = p[31:0];
      e = (p > MAX_P) || (p < MIN_N);
    end else if (b == 32'd0) begin
      r = 32'd0;
      e = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r = 32'h8000_0000;
      e = 1'b1;
    end else begin
      p = la / lb;
      r = p[31:0];
      e = 1'b0;
    end
  endfunction

  task automatic start_op(input bit is_div, input bit both, input logic [31:0] a, input logic [31:0] b);
    bit eff_div;
    @(negedge clock);
    ctrl_MULT     = !is_div || both;
    ctrl_DIV      = is_div || both;
    data_operandA = a;
    data_operandB = b;
    @(posedge clock);
    #1;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
    eff_div = is_div && !both;
    model(eff_div, a, b, exp_res, exp_exc);
    exp_at   = cyc + ((eff_div && b == 32'd0) ? 1 : 36);
    held_exc = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic lit_op(input string name, input bit is_div, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] lr, input logic le);
    logic [31:0] r;
    logic        e;
    model(is_div, a, b, r, e);
    chk({name, "_model_res"}, r, lr);
    chk({name, "_model_exc"}, {31'd0, e}, {31'd0, le});
    start_op(is_div, 1'b0, a, b);
    wait_cycles(38);
    chk({name, "_dut_res"}, data_result, lr);
    chk({name, "_dut_exc"}, {31'd0, data_exception}, {31'd0, le});
  endtask

  function automatic logic [31:0] rnd_operand();
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0: v = 32'h8000_0000;
      1: v = 32'hFFFF_FFFF;
      2: v = 32'($urandom_range(0, 20)) - 32'd10;
      3: v = 32'($urandom_range(0, 70000));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    forever begin
      @(negedge clock);
      chk("alu_shamt", {27'd0, alu_shamt}, 32'd0);
      chk("alu_opcode_legal", {31'd0, (alu_opcode <= 5'd1)}, 32'd1);
      if (exp_at >= 0 && cyc == exp_at) begin
        chk("rdy_high", {31'd0, data_resultRDY}, 32'd1);
        chk("result", data_result, exp_res);
        chk("exception", {31'd0, data_exception}, {31'd0, exp_exc});
        held_res = exp_res;
        held_exc = exp_exc;
        exp_at   = -1;
      end else begin
        chk("rdy_low", {31'd0, data_resultRDY}, 32'd0);
        chk("result_hold", data_result, held_res);
        chk("exception_hold", {31'd0, data_exception}, {31'd0, held_exc});
      end
    end
  end

  initial begin
    wait_cycles(3);
    chk("reset_result", data_result, 32'd0);
    chk("reset_exc", {31'd0, data_exception}, 32'd0);
    chk("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
    reset_n = 1'b1;
    wait_cycles(2);

    lit_op("mul_7_m3", 1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
    lit_op("div_m100_7", 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 1'b0);
    lit_op("div_by_zero", 1'b1, 32'd100, 32'd0, 32'd0, 1'b1);
    lit_op("mul_ovf", 1'b0, 32'h0001_0000, 32'h0001_0000, 32'd0, 1'b1);
    lit_op("mul_min_1", 1'b0, 32'h8000_0000, 32'd1, 32'h8000_0000, 1'b0);
    lit_op("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
    lit_op("div_min_min", 1'b1, 32'h8000_0000, 32'h8000_0000, 32'd1, 1'b0);

    // Both starts high: multiply takes priority.
    start_op(1'b1, 1'b1, 32'd9, 32'd3);
    wait_cycles(38);
    chk("both_start_mult", data_result, 32'd27);

    // Restart: a divide issued mid-multiply replaces it.
    start_op(1'b0, 1'b0, 32'd5, 32'd5);
    wait_cycles(9);
    start_op(1'b1, 1'b0, 32'd20, 32'd4);
    wait_cycles(38);
    chk("restart_div", data_result, 32'd5);

    // Asynchronous reset mid-iteration.
    start_op(1'b0, 1'b0, 32'd123, 32'd456);
    wait_cycles(10);
    @(posedge clock);
    #2;
    reset_n  = 1'b0;
    exp_at   = -1;
    held_res = '0;
    held_exc = 1'b0;
    #1;
    chk("async_rst_result", data_result, 32'd0);
    chk("async_rst_exc", {31'd0, data_exception}, 32'd0);
    chk("async_rst_rdy", {31'd0, data_resultRDY}, 32'd0);
    wait_cycles(2);
    reset_n = 1'b1;
    wait_cycles(40);
    lit_op("mul_6_6", 1'b0, 32'd6, 32'd6, 32'd36, 1'b0);

    for (int i = 0; i < 40; i++) begin
      start_op(($urandom_range(0, 1) == 1), 1'b0, rnd_operand(), rnd_operand());
      wait_cycles(37 + $urandom_range(0, 3));
    end

    wait_cycles(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
